// File: rtl/module_keypad_scanner_pkg.sv
// Shared types and key encoding for the 4x4 keypad scanner.
package pkg_keypad;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } keypad_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_F     = 4'hF;

    // Physical layout: rows 0..3 top to bottom, columns 0..3 left to right.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_ENTER;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_F;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Only meaningful for a one-hot row pattern.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/module_keypad_scanner_sync.sv
// Two-stage synchronizer bringing the asynchronous row lines into the clock domain.
module module_keypad_sync (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, hex encode, one pulse per press.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid_o every REPEAT_COUNT cycles while a key is held.
module module_keypad_scanner
    import pkg_keypad::*;
#(
    parameter int unsigned SCAN_COUNT     = 10_000,
    parameter int unsigned SCAN_BITS      = 14,
    parameter int unsigned DEBOUNCE_COUNT = 100_000,
    parameter int unsigned DEBOUNCE_BITS  = 17,
    parameter int unsigned REPEAT_COUNT   = 5_000_000,
    parameter int unsigned REPEAT_BITS    = 23
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] fila_i,
    output logic [1:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam logic [SCAN_BITS-1:0]     SCAN_LAST = SCAN_BITS'(SCAN_COUNT - 1);
    localparam logic [DEBOUNCE_BITS-1:0] DEB_LAST  = DEBOUNCE_BITS'(DEBOUNCE_COUNT - 1);

    logic [3:0] rows_s;
    logic       row_valid;

    keypad_state_t            state_q, state_d;
    logic [1:0]               col_q, col_d;
    logic [SCAN_BITS-1:0]     scan_cnt_q, scan_cnt_d;
    logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]               cand_rows_q, cand_rows_d;
    logic [1:0]               cand_col_q, cand_col_d;
    logic [3:0]               key_code_q, key_code_d;
    logic                     key_valid_q, key_valid_d;
    logic                     key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [REPEAT_BITS-1:0] REP_LAST = REPEAT_BITS'(REPEAT_COUNT - 1);
    logic [REPEAT_BITS-1:0] rep_cnt_q, rep_cnt_d;
`else
    logic repeat_cfg_unused;
    assign repeat_cfg_unused = ^{REPEAT_COUNT, REPEAT_BITS};
`endif

    module_keypad_sync u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (fila_i),
        .q_o     (rows_s)
    );

    // Simultaneous rows are ambiguous and treated as no key at all.
    assign row_valid = $onehot(rows_s);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        cand_rows_d = cand_rows_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        case (state_q)
            SCAN: begin
                if (row_valid) begin
                    cand_rows_d = rows_s;
                    cand_col_d  = col_q;
                    deb_cnt_d   = '0;
                    scan_cnt_d  = '0;
                    state_d     = DEBOUNCE;
                end else if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    col_d      = col_q + 2'd1;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rows_s != cand_rows_q) begin
                    deb_cnt_d = '0;
                    state_d   = SCAN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    key_code_d  = key_map(row_index(cand_rows_q), cand_col_q);
                    key_valid_d = 1'b1;
                    deb_cnt_d   = '0;
                    state_d     = PRESSED;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (rows_s == 4'b0000) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d   = '0;
                    key_valid_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                // RELEASE: any row activity restarts the quiet-time measurement.
                if (rows_s != 4'b0000) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        endcase
        key_held_d = (state_d == PRESSED) || (state_d == RELEASE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= SCAN;
            col_q       <= '0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            cand_rows_q <= '0;
            cand_col_q  <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            cand_rows_q <= cand_rows_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign col_o       = col_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Scoreboard bench for module_keypad_scanner with a behavioural keypad matrix model.
module tb_module_keypad_scanner;

    localparam int SC = 4;
    localparam int DC = 8;
    localparam int RC = 20;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] fila;
    logic [1:0] col;
    logic [3:0] code;
    logic       valid;
    logic       held;

    // Keypad model: the pressed switch connects its row to the driven column.
    logic       key_on = 1'b0;
    logic       two_row = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;

    logic [3:0] ref_tab [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                   '{4'h4, 4'h5, 4'h6, 4'hB},
                                   '{4'h7, 4'h8, 4'h9, 4'hC},
                                   '{4'hE, 4'h0, 4'hF, 4'hD}};

    logic [3:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        fila = 4'b0000;
        if (key_on && col == key_c) begin
            fila[key_r] = 1'b1;
            if (two_row) fila[2] = 1'b1;
        end
    end

    module_keypad_scanner #(
        .SCAN_COUNT(SC), .SCAN_BITS(14),
        .DEBOUNCE_COUNT(DC), .DEBOUNCE_BITS(17),
        .REPEAT_COUNT(RC), .REPEAT_BITS(23)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .fila_i(fila),
        .col_o(col), .key_code_o(code), .key_valid_o(valid), .key_held_o(held)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            chk("no_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) chk("unexpected_pulse", {28'd0, code}, 32'hFFFF_FFFF);
            else                   chk("key_code", {28'd0, code}, {28'd0, exp_q.pop_front()});
        end
        prev_valid <= valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int bound, output int n);
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n = i;
                return;
            end
        end
        n = -1;
    endtask

    // After the first pulse: hold, release with optional bounce, confirm release.
    task automatic finish_press(input logic [1:0] r, input logic [1:0] c, input int bounces);
        chk("held_after_pulse", {31'd0, held}, 32'd1);
        for (int e = 0; e < EXTRA; e++) exp_q.push_back(ref_tab[r][c]);
        cyc($urandom_range(62, 75));
        for (int b = 0; b < bounces; b++) begin
            key_on = 1'b0; cyc($urandom_range(1, 4));
            key_on = 1'b1; cyc($urandom_range(1, 4));
        end
        key_on = 1'b0;
        cyc(DC + 15);
        chk("released", {31'd0, held}, 32'd0);
    endtask

    task automatic press_random(input logic [1:0] r, input logic [1:0] c, input int bounces);
        int n;
        key_r = r;
        key_c = c;
        exp_q.push_back(ref_tab[r][c]);
        for (int b = 0; b < bounces; b++) begin
            key_on = 1'b1; cyc($urandom_range(1, 5));
            key_on = 1'b0; cyc($urandom_range(1, 4));
        end
        key_on = 1'b1;
        wait_pulse(200, n);
        chk("press_detected", {31'd0, n > 0}, 32'd1);
        finish_press(r, c, bounces);
    endtask

    initial begin
        int n;
        logic [1:0] last;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] last;
        cyc(3);
        chk("rst_col", {30'd0, col}, 32'd0);
        chk("rst_code", {28'd0, code}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_held", {31'd0, held}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("idle_col", {30'd0, col}, (k / SC) % 4);
        end

        // Directed latency: row 1 appears the cycle column 2 starts.
        last = col;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col == 2'd2 && last == 2'd1) break;
            last = col;
        end
        key_r = 2'd1;
        key_c = 2'd2;
        exp_q.push_back(ref_tab[1][2]);
        key_on = 1'b1;
        wait_pulse(40, n);
        chk("latency_row1_col2", n, DC + 3);
        chk("col_frozen", {30'd0, col}, 32'd2);
        finish_press(2'd1, 2'd2, 0);

        for (int p = 0; p < 10; p++)
            press_random(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 3));

        // Two rows on the same column: ambiguous, must be ignored.
        key_r = 2'd0;
        key_c = 2'($urandom_range(0, 3));
        two_row = 1'b1;
        key_on = 1'b1;
        cyc(60);
        chk("two_row_no_hold", {31'd0, held}, 32'd0);
        key_on = 1'b0;
        two_row = 1'b0;
        cyc(5);

        // Reset while a key is held, then recover with a fresh debounced pulse.
        key_r = 2'd3;
        key_c = 2'd1;
        exp_q.push_back(ref_tab[3][1]);
        key_on = 1'b1;
        wait_pulse(200, n);
        chk("reset_case_pressed", {31'd0, n > 0}, 32'd1);
        cyc(10);
        rst_n = 1'b0;
        #1;
        chk("midrst_col", {30'd0, col}, 32'd0);
        chk("midrst_code", {28'd0, code}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_held", {31'd0, held}, 32'd0);
        cyc(3);
        exp_q.push_back(ref_tab[3][1]);
        rst_n = 1'b1;
        wait_pulse(200, n);
        chk("post_reset_debounced", {31'd0, n >= DC + 3}, 32'd1);
        finish_press(2'd3, 2'd1, 1);

        cyc(10);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
